// File: rtl/booth8_seq_mult.sv
// Iterative radix-8 Booth multiplier: one 3-bit multiplier group per clock into a
// single accumulator, with signed/unsigned operands selected per transaction.
module booth8_seq_mult #(
   parameter int BITS = 11,
   parameter int NGRP = (BITS + 3) / 3
) (
   input  logic              iClk,
   input  logic              iRst,
   input  logic              iValid,
   output logic              oReady,
   input  logic              iSigned,
   input  logic [BITS-1:0]   iM,
   input  logic [BITS-1:0]   iQ,
   output logic              oValid,
   input  logic              iReady,
   output logic [2*BITS-1:0] oZ,
   output logic              oBusy
);

   localparam int MW = BITS + 3;
   localparam int PW = BITS + 4;
   localparam int QW = 3 * NGRP + 1;
   localparam int EW = QW - 1 - BITS;
   localparam int AW = 2 * BITS + 3;
   localparam int CW = $clog2(NGRP) + 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t          state_reg, state_next;
   logic [CW-1:0]   cnt_reg;
   logic [MW-1:0]   m_reg, m3_reg;
   logic [QW-1:0]   q_reg;
   logic [AW-1:0]   acc_reg;

   logic            accept;
   logic            last_grp;
   logic [MW-1:0]   m_ext;
   logic [QW-1:0]   q_ext;
   logic [PW-1:0]   m1_x, m2_x, m3_x, m4_x;
   logic [PW-1:0]   mag;
   logic            neg;
   logic [PW-1:0]   pp;
   logic [AW-1:0]   pp_ext;
   logic [7:0]      shamt;
   logic            unused_acc_hi;

   assign accept   = iValid && (state_reg == IDLE);
   assign last_grp = (cnt_reg == CW'(NGRP - 1));

   // Zero-extension in unsigned mode keeps the top Booth window non-negative.
   assign m_ext = iSigned ? {{3{iM[BITS-1]}}, iM} : {3'b000, iM};
   assign q_ext = {{EW{iSigned & iQ[BITS-1]}}, iQ, 1'b0};

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (iValid) state_next = CALC;
         CALC:    if (last_grp) state_next = DONE;
         DONE:    if (iReady) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      oReady = (state_reg == IDLE);
      oValid = (state_reg == DONE);
      oBusy  = (state_reg != IDLE);
      oZ     = acc_reg[2*BITS-1:0];
   end

   assign m1_x = {m_reg[MW-1], m_reg};
   assign m2_x = m1_x << 1;
   assign m3_x = {m3_reg[MW-1], m3_reg};
   assign m4_x = m1_x << 2;

   always_comb begin
      mag = '0;
      neg = 1'b0;
      case (q_reg[3:0])
         4'b0001, 4'b0010: mag = m1_x;
         4'b0011, 4'b0100: mag = m2_x;
         4'b0101, 4'b0110: mag = m3_x;
         4'b0111:          mag = m4_x;
         4'b1000:          begin mag = m4_x; neg = 1'b1; end
         4'b1001, 4'b1010: begin mag = m3_x; neg = 1'b1; end
         4'b1011, 4'b1100: begin mag = m2_x; neg = 1'b1; end
         4'b1101, 4'b1110: begin mag = m1_x; neg = 1'b1; end
         default:          mag = '0;
      endcase
   end

   assign pp     = neg ? (~mag + PW'(1)) : mag;
   assign pp_ext = {{(AW - PW){pp[PW-1]}}, pp};
   assign shamt  = 8'(cnt_reg) * 8'd3;

   // The multiplier shifts right so the current window always sits in q_reg[3:0].
   always_ff @(posedge iClk) begin
      if (iRst) begin
         cnt_reg <= '0;
         acc_reg <= '0;
         m_reg   <= '0;
         m3_reg  <= '0;
         q_reg   <= '0;
      end else if (accept) begin
         cnt_reg <= '0;
         acc_reg <= '0;
         m_reg   <= m_ext;
         m3_reg  <= m_ext + (m_ext << 1);
         q_reg   <= q_ext;
      end else if (state_reg == CALC) begin
         cnt_reg <= cnt_reg + CW'(1);
         acc_reg <= acc_reg + (pp_ext << shamt);
         q_reg   <= q_reg >> 3;
      end
   end

   assign unused_acc_hi = ^acc_reg[AW-1:2*BITS];

endmodule

// File: tb/tb_booth8_seq_mult.sv
// Directed-vector bench for booth8_seq_mult at BITS=11 (half-precision mantissa).
module tb_booth8_seq_mult;

   localparam int BITS = 11;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              out_ready;
   logic              in_signed;
   logic [BITS-1:0]   m_in, q_in;
   logic              out_valid;
   logic              dn_ready;
   logic [2*BITS-1:0] z_out;
   logic              busy;

   int pass_cnt  = 0;
   int total_cnt = 0;

   booth8_seq_mult #(.BITS(BITS)) dut (
      .iClk(clk), .iRst(rst), .iValid(in_valid), .oReady(out_ready),
      .iSigned(in_signed), .iM(m_in), .iQ(q_in), .oValid(out_valid),
      .iReady(dn_ready), .oZ(z_out), .oBusy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one operation to the point where oValid is seen; the result is consumed
   // on the following edge. Operands are scrambled after accept on purpose.
   task automatic do_op(input logic [BITS-1:0] m, input logic [BITS-1:0] q,
                        input logic s, output logic [2*BITS-1:0] z, output int lat);
      int w = 0;
      while (!out_ready && w < 50) begin tick(); w++; end
      in_valid = 1'b1; m_in = m; q_in = q; in_signed = s; dn_ready = 1'b1;
      tick();
      in_valid = 1'b0; m_in = ~m; q_in = ~q; in_signed = ~s;
      lat = 0;
      while (!out_valid && lat < 50) begin tick(); lat++; end
      z = z_out;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_signed = 1'b0; m_in = '0; q_in = '0; dn_ready = 1'b1;
      tick(); tick();
      rst = 1'b0;
      total_cnt++;
      if ({out_ready, out_valid, busy} !== 3'b100 || z_out !== '0)
         $display("FAIL reset: rdy/vld/busy=%b oZ=%h, required 100 and 000000",
                  {out_ready, out_valid, busy}, z_out);
      else pass_cnt++;
      $display("reset: rdy=%b vld=%b busy=%b oZ=%h", out_ready, out_valid, busy, z_out);
   endtask

   task automatic test_unsigned_max();
      logic [2*BITS-1:0] z; int lat;
      do_op(11'h7FF, 11'h7FF, 1'b0, z, lat);
      $display("unsigned 7FF*7FF: oZ=%h lat=%0d", z, lat);
      total_cnt++;
      if (z !== 22'h3FF001) $display("FAIL umax_z: got %h, required 3ff001", z);
      else pass_cnt++;
      total_cnt++;
      if (lat !== 4) $display("FAIL umax_lat: got %0d, required 4", lat);
      else pass_cnt++;
   endtask

   task automatic test_signed();
      logic [BITS-1:0]   tm [4] = '{11'h7FF, 11'h7FF, 11'h400, 11'h123};
      logic [BITS-1:0]   tq [4] = '{11'h005, 11'h005, 11'h400, 11'h000};
      logic              ts [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
      logic [2*BITS-1:0] te [4] = '{22'h3FFFFB, 22'h0027FB, 22'h100000, 22'h000000};
      logic [2*BITS-1:0] z; int lat;
      for (int i = 0; i < 4; i++) begin
         do_op(tm[i], tq[i], ts[i], z, lat);
         $display("signed_case %0d: M=%h Q=%h s=%b oZ=%h lat=%0d", i, tm[i], tq[i], ts[i], z, lat);
         total_cnt++;
         if (z !== te[i] || lat !== 4)
            $display("FAIL signed_case%0d: oZ=%h lat=%0d, required %h lat=4", i, z, lat, te[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_vectors();
      logic [BITS-1:0]   tm [6] = '{11'h400, 11'h3FF, 11'h400, 11'h400, 11'h555, 11'h555};
      logic [BITS-1:0]   tq [6] = '{11'h7FF, 11'h3FF, 11'h3FF, 11'h3FF, 11'h003, 11'h003};
      logic              ts [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [2*BITS-1:0] te [6] = '{22'h000400, 22'h0FF801, 22'h300400,
                                    22'h0FFC00, 22'h000FFF, 22'h3FF7FF};
      logic [2*BITS-1:0] z; int lat;
      for (int i = 0; i < 6; i++) begin
         do_op(tm[i], tq[i], ts[i], z, lat);
         $display("vector %0d: M=%h Q=%h s=%b oZ=%h lat=%0d", i, tm[i], tq[i], ts[i], z, lat);
         total_cnt++;
         if (z !== te[i] || lat !== 4)
            $display("FAIL vector%0d: oZ=%h lat=%0d, required %h lat=4", i, z, lat, te[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_backpressure();
      int lat;
      int bad = 0;
      in_valid = 1'b1; m_in = 11'h00C; q_in = 11'h00A; in_signed = 1'b0; dn_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 50) begin tick(); lat++; end
      total_cnt++;
      if (lat !== 4 || z_out !== 22'h000078)
         $display("FAIL bp_first: oZ=%h lat=%0d, required 000078 lat=4", z_out, lat);
      else pass_cnt++;
      // Queue the next operation while the result is stalled.
      in_valid = 1'b1; m_in = 11'h003; q_in = 11'h007; in_signed = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (out_valid !== 1'b1 || z_out !== 22'h000078 || out_ready !== 1'b0) bad++;
      end
      total_cnt++;
      if (bad != 0) $display("FAIL bp_hold: %0d unstable cycles, required 0", bad);
      else pass_cnt++;
      $display("backpressure: held 10 cycles, unstable=%0d", bad);
      dn_ready = 1'b1;
      tick();
      total_cnt++;
      if ({out_ready, out_valid, busy} !== 3'b100)
         $display("FAIL bp_release: rdy/vld/busy=%b, required 100", {out_ready, out_valid, busy});
      else pass_cnt++;
      tick();
      in_valid = 1'b0;
      total_cnt++;
      if ({out_ready, busy} !== 2'b01)
         $display("FAIL bp_queued_accept: rdy/busy=%b, required 01", {out_ready, busy});
      else pass_cnt++;
      lat = 0;
      while (!out_valid && lat < 50) begin tick(); lat++; end
      $display("queued op 3*7: oZ=%h lat=%0d", z_out, lat);
      total_cnt++;
      if (lat !== 4 || z_out !== 22'h000015)
         $display("FAIL bp_queued_result: oZ=%h lat=%0d, required 000015 lat=4", z_out, lat);
      else pass_cnt++;
      tick();
   endtask

   task automatic test_reset_mid_calc();
      logic [2*BITS-1:0] z; int lat;
      int stale = 0;
      in_valid = 1'b1; m_in = 11'h7FF; q_in = 11'h7FF; in_signed = 1'b0; dn_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total_cnt++;
      if ({out_ready, out_valid, busy} !== 3'b100 || z_out !== '0)
         $display("FAIL midreset: rdy/vld/busy=%b oZ=%h, required 100 and 000000",
                  {out_ready, out_valid, busy}, z_out);
      else pass_cnt++;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (out_valid !== 1'b0 || busy !== 1'b0) stale++;
      end
      total_cnt++;
      if (stale != 0) $display("FAIL midreset_stale: %0d cycles with activity, required 0", stale);
      else pass_cnt++;
      do_op(11'h003, 11'h005, 1'b0, z, lat);
      $display("after reset 3*5: oZ=%h lat=%0d", z, lat);
      total_cnt++;
      if (z !== 22'd15 || lat !== 4)
         $display("FAIL midreset_fresh: oZ=%h lat=%0d, required 00000f lat=4", z, lat);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_unsigned_max();
      test_signed();
      test_vectors();
      test_backpressure();
      test_reset_mid_calc();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/booth8_seq_mult.md
Name: booth8_seq_mult

Overview:
- Parametrised, iterative radix-8 Booth multiplier with operand width BITS.
- Supports both signed (two's complement) and unsigned operands, selected per transaction.
- Retires one 3-bit multiplier group per clock into a single accumulator, trading latency for area.
- Ready/valid handshakes on input and output. Sits in the FP datapath as the mantissa multiplier, with BITS=11 for half precision and 24 for single precision.

Parameters:
- BITS, 11, operand width of iM and iQ; legal range 4..32.
- NGRP, (BITS+3)/3 (integer divide), number of Booth groups; derived, do not override.

Ports:
- iClk  input  1  clock; all state changes on the rising edge.
- iRst  input  1  synchronous, active-high reset.
- iValid  input  1  input operands valid.
- oReady  output  1  block can accept operands; high only in IDLE.
- iSigned  input  1  1 = operands are two's complement, 0 = unsigned; sampled with the operands.
- iM  input  BITS  multiplicand.
- iQ  input  BITS  multiplier.
- oValid  output  1  oZ holds a completed product.
- iReady  input  1  downstream accepts oZ.
- oZ  output  2*BITS  product; exact two's complement (signed) or unsigned result.
- oBusy  output  1  high in CALC or DONE.

Behaviour:
- Reset (iRst=1 at an edge) forces IDLE regardless of current state:
  - oValid=0, oBusy=0, oZ=0, group counter=0, accumulator=0.
  - oReady=1 from the next cycle.
  - Any in-flight operation is discarded; no result is produced for it.
- State machine IDLE -> CALC -> DONE -> IDLE.
  - IDLE: oReady=1. An accept occurs when iValid&oReady is high at an edge.
  - On accept, register the following and go to CALC with count=0:
    - M extended to BITS+3 bits: sign-extended if iSigned, else zero-extended.
    - 3M, computed combinationally as M+(M<<1) and registered.
    - Q extended to 3*NGRP+1 bits as {ext, Q, 1'b0}: sign-extended if iSigned, else zero-extended.
  - CALC, one edge per group g = 0..NGRP-1:
    - Decode window Q[3g+3:3g] into a digit d in {-4..+4}.
    - Digit mapping: 0000/1111->0; 0001,0010->+1; 0011,0100->+2; 0101,0110->+3; 0111->+4; 1000->-4; 1001,1010->-3; 1011,1100->-2; 1101,1110->-1.
    - Add d*M (sign-extended, two's complement negation) shifted left by 3g to a 2*BITS+3 bit accumulator.
    - After the edge for g=NGRP-1, go to DONE.
  - DONE: oValid=1, oZ = accumulator[2*BITS-1:0].
    - oZ and oValid are held stable while iReady=0, with no timeout.
    - The edge with iReady=1 returns to IDLE and clears oValid.
- Latency and throughput:
  - oValid rises exactly NGRP edges after the accepting edge (4 for BITS=11).
  - Minimum initiation interval is NGRP+2 cycles; there is no accept while oBusy=1.
- Operands and iSigned are ignored outside IDLE; changing them mid-operation has no effect.
- Unsigned mode needs the zero-extension bit so the top group never decodes negative; NGRP guarantees that bit exists for every legal BITS.
- Arithmetic:
  - The accumulator wraps modulo 2^(2*BITS+3).
  - The truncated 2*BITS result is exact in both modes. Signed range: -2^(BITS-1) * -2^(BITS-1) = 2^(2*BITS-2), which fits.
- iValid asserted while in DONE with iReady=1: not accepted that cycle; it is accepted in the following IDLE cycle if still asserted.

Test Plan:
- BITS=11, unsigned, iM=0x7FF, iQ=0x7FF -> oValid 4 cycles after accept, oZ=0x3FF001 (4190209).
- BITS=11, signed:
  - iM=0x7FF (-1), iQ=0x005 -> oZ=0x3FFFFB (-5).
  - Same operands unsigned -> oZ=0x0027FB (10235).
- BITS=11, signed, iM=iQ=0x400 (-1024) -> oZ=0x100000. Then iQ=0 with any iM -> oZ=0.
- Backpressure:
  - Hold iReady=0 for 10 cycles in DONE -> oValid and oZ stable and oReady=0 throughout.
  - Release iReady -> oReady=1 next cycle, and a queued iValid is accepted.
- Reset mid-CALC: assert iRst at the 2nd CALC edge -> next cycle oValid=0, oZ=0, oReady=1, and no stale result ever appears. A fresh 3*5 operation then gives oZ=15.
- BITS=24, 5000 random operand pairs with random iSigned and random iReady stalls -> oZ matches the reference product every time, and latency is always 9 edges.
